// File: rtl/absorb_unit.sv
// Purpose: collects 64-bit message lanes into one rate-sized block for the Keccak permutation/XOR stage.
// Latency: an accepted lane appears in rate_buf right after its edge; full rises right after the last lane's edge.
// Backpressure: ready drops once the block is full; lanes offered while full are dropped until reset.
module absorb_unit #(
    parameter int RATE_BITS = 1088
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    output logic                 ready,
    output logic                 full,
    output logic [RATE_BITS-1:0] rate_buf
);

    localparam int WORDS = RATE_BITS / 64;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic {
        LOADING = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RATE_BITS-1:0]   buf_q, buf_d;
    logic                   full_q, full_d;

    // Next-state: write the lane at the current slot, advance the counter, and close the block on the last lane.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        full_d  = full_q;
        if (state_q == LOADING && in_valid) begin
            for (int w = 0; w < WORDS; w++) begin
                if (cnt_q == CW'(w)) begin
                    buf_d[w*64 +: 64] = in_data;
                end
            end
            if (cnt_q == LAST_IDX) begin
                state_d = FULL;
                full_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset wins over a simultaneous lane and discards any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOADING;
            cnt_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
        end
    end

    // ready comes straight from the state register so nothing combinational loops back from in_valid.
    assign ready    = (state_q == LOADING);
    assign full     = full_q;
    assign rate_buf = buf_q;

endmodule

// File: tb/tb_absorb_unit.sv
// Bench for absorb_unit: SHAKE256 (1088) and SHAKE128 (1344) instances side by side.
module tb_absorb_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SHAKE256-width instance
    logic          rst0, vld0, rdy0, full0;
    logic [63:0]   dat0;
    logic [1087:0] buf0;
    // SHAKE128-width instance
    logic          rst1, vld1, rdy1, full1;
    logic [63:0]   dat1;
    logic [1343:0] buf1;

    absorb_unit #(.RATE_BITS(1088)) u0 (
        .clk(clk), .reset(rst0), .in_valid(vld0), .in_data(dat0),
        .ready(rdy0), .full(full0), .rate_buf(buf0)
    );

    absorb_unit #(.RATE_BITS(1344)) u1 (
        .clk(clk), .reset(rst1), .in_valid(vld1), .in_data(dat1),
        .ready(rdy1), .full(full1), .rate_buf(buf1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the 1088-bit instance
    logic [63:0] m0 [17];
    int          m0_cnt;
    bit          m0_full;

    typedef struct {
        int          idx;
        logic [63:0] dat;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit          vld;
        logic [63:0] dat;
        bit          exp_rdy;
        bit          exp_full;
    } vec_t;
    vec_t tbl [34];

    function automatic logic [63:0] lane_a(input int i);
        return 64'hF0F0_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [63:0] lane_b(input int i);
        return 64'h1234_5678_0000_0000 | (64'(i) << 8) | 64'h5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear0;
        for (int i = 0; i < 17; i++) m0[i] = '0;
        m0_cnt  = 0;
        m0_full = 1'b0;
        sbq.delete();
    endtask

    // Drive one cycle on instance 0; accepted lanes go to the scoreboard and are checked right after the edge.
    task automatic drive0(input bit v, input logic [63:0] d);
        vld0 = v;
        dat0 = d;
        if (v && !m0_full) begin
            sbq.push_back('{m0_cnt, d});
            m0[m0_cnt] = d;
            m0_cnt++;
            if (m0_cnt == 17) begin
                m0_full = 1'b1;
                m0_cnt  = 0;
            end
        end
        tick;
        vld0 = 1'b0;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            chk($sformatf("sb_lane%0d", e.idx), buf0[e.idx*64 +: 64], e.dat);
        end
    endtask

    task automatic check_buf0(input string tag);
        for (int i = 0; i < 17; i++)
            chk($sformatf("%s_buf%0d", tag, i), buf0[i*64 +: 64], m0[i]);
        chk({tag, "_ready"}, 64'(rdy0), 64'(!m0_full));
        chk({tag, "_full"}, 64'(full0), 64'(m0_full));
    endtask

    // Reset with in_valid held high to show reset wins; outputs checked after the first reset edge.
    task automatic reset0(input int n);
        rst0 = 1'b1;
        vld0 = 1'b1;
        dat0 = 64'hBAD0_BAD0_BAD0_BAD0;
        model_clear0();
        tick;
        check_buf0("rst");
        repeat (n - 1) tick;
        rst0 = 1'b0;
        vld0 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; vld0 = 1'b0; dat0 = '0;
        rst1 = 1'b1; vld1 = 1'b0; dat1 = '0;

        // Spaced lanes: each lane is a one-cycle pulse followed by an idle cycle.
        for (int i = 0; i < 17; i++) begin
            tbl[2*i]   = '{1'b1, lane_a(i), (i != 16), (i == 16)};
            tbl[2*i+1] = '{1'b0, 64'(i * 3 + 7), (i != 16), (i == 16)};
        end

        reset0(3);
        for (int k = 0; k < 34; k++) begin
            drive0(tbl[k].vld, tbl[k].dat);
            chk($sformatf("tbl%0d_ready", k), 64'(rdy0), 64'(tbl[k].exp_rdy));
            chk($sformatf("tbl%0d_full", k), 64'(full0), 64'(tbl[k].exp_full));
        end
        repeat (10) drive0(1'b0, '0);
        chk("spaced_full_hold", 64'(full0), 64'd1);
        for (int i = 0; i < 17; i++)
            chk($sformatf("spaced_lane%0d", i), buf0[i*64 +: 64], lane_a(i));
        chk("spaced_ready", 64'(rdy0), 64'd0);

        // Overflow while full: lanes offered are dropped.
        repeat (5) drive0(1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
        check_buf0("ovf");

        // Back-to-back lanes.
        reset0(1);
        for (int i = 0; i < 17; i++) begin
            drive0(1'b1, lane_a(i));
            chk($sformatf("b2b_full%0d", i), 64'(full0), 64'(i == 16));
            chk($sformatf("b2b_ready%0d", i), 64'(rdy0), 64'(i != 16));
        end
        for (int i = 0; i < 17; i++)
            chk($sformatf("b2b_lane%0d", i), buf0[i*64 +: 64], lane_a(i));

        // Partial fill followed by a long gap.
        reset0(2);
        for (int i = 0; i < 5; i++) drive0(1'b1, lane_b(i));
        repeat (20) drive0(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check_buf0("partial");
        chk("partial_upper_or", 64'(|buf0[1087:320]), 64'd0);

        // Reset mid-fill after 8 lanes, then a fresh block.
        for (int i = 5; i < 8; i++) drive0(1'b1, lane_b(i));
        check_buf0("mid8");
        reset0(1);
        chk("mid_rst_all_zero", 64'(|buf0), 64'd0);
        for (int i = 0; i < 17; i++) drive0(1'b1, lane_b(i + 40));
        chk("restart_lane0", buf0[63:0], lane_b(40));
        check_buf0("restart");

        // SHAKE128 width: full only after lane 21.
        rst1 = 1'b1;
        repeat (3) tick;
        chk("w1344_rst_full", 64'(full1), 64'd0);
        chk("w1344_rst_ready", 64'(rdy1), 64'd1);
        rst1 = 1'b0;
        for (int i = 0; i < 21; i++) begin
            vld1 = 1'b1;
            dat1 = lane_b(i);
            tick;
            vld1 = 1'b0;
            chk($sformatf("w1344_full%0d", i), 64'(full1), 64'(i == 20));
            if (i % 2 == 1) tick;
        end
        for (int i = 0; i < 21; i++)
            chk($sformatf("w1344_lane%0d", i), buf1[i*64 +: 64], lane_b(i));
        chk("w1344_top", buf1[1343:1280], lane_b(20));
        chk("w1344_ready", 64'(rdy1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/absorb_unit.md
# absorb_unit

Input-side absorb buffer for the SHAKE/Keccak core. It collects a stream of 64-bit message lanes into one rate-sized block, `rate_buf`, and flags `full` when the block is complete. The permutation/XOR stage reads the block from here. Each block is a one-shot fill: after `full`, the block holds the data until `reset` restarts it.

## Interface
- `RATE_BITS`, default 1088, rate in bits.
  - 1088 for SHAKE256, 1344 for SHAKE128.
  - Must be a positive multiple of 64.
  - WORDS = RATE_BITS/64.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_data` carries a lane this cycle.
- `in_data`  input  64  message lane.
- `ready`  output  1  unit accepts a lane this cycle.
- `full`  output  1  all WORDS lanes captured; `rate_buf` holds a complete block.
- `rate_buf`  output  RATE_BITS  assembled block.

## Operation
- State machine with two states, LOADING and FULL, plus a word counter `cnt`.
  - `cnt` is $clog2(WORDS) bits wide, with a minimum of 1 bit.
- Reset (`reset`=1 at a rising edge) forces:
  - state = LOADING
  - `cnt` = 0
  - `rate_buf` = 0
  - `full` = 0
  - Reset takes priority over any simultaneous `in_valid`.
  - Reset mid-fill discards the partial block.
- `ready` = 1 in LOADING and 0 in FULL. It is decoded directly from the state register; no input feeds it combinationally.
- Accept condition: `in_valid` & `ready` at a rising edge.
  - On accept, `rate_buf[cnt*64 +: 64]` <= `in_data`. The first lane goes to [63:0], the second to [127:64], and so on, so the last lane lands in the top 64 bits.
  - On accept with `cnt` < WORDS-1: `cnt` <= `cnt`+1.
  - On accept with `cnt` = WORDS-1: state <= FULL, `full` <= 1, `cnt` <= 0.
- LOADING with `in_valid`=0: nothing changes. Gaps of any length between lanes are legal, and `in_data` is don't-care.
- FULL:
  - `full` stays 1 and `rate_buf` is frozen.
  - `in_valid` is ignored; lanes offered here are dropped, not queued.
  - The only exit is `reset`, which returns to LOADING with a cleared buffer. The consumer pulses `reset` after reading the block to start the next one.
- Lanes that have not yet been written read as 0 in `rate_buf`.

## Timing
- `full`, `rate_buf` and state are all registered.
- Back-to-back lanes are accepted one per cycle. A full block takes WORDS consecutive accept cycles (17 for 1088, 21 for 1344).
- Latency:
  - A lane accepted at edge N is visible in `rate_buf` right after edge N.
  - `full` rises right after the edge that accepts lane WORDS-1.
  - `ready` falls in that same cycle.
- `full` holds indefinitely until reset, with no timeout. It must still read 1 any number of cycles after the last lane.
- Reset values of the outputs: `ready`=1, `full`=0, `rate_buf`=0. Each is valid from the first edge with `reset`=1.

## Test plan
- Default width, spaced lanes:
  - Stimulus: reset for 3 cycles, then send lane i = 64'hF0F0_0000_0000_0000 | i for i = 0..16, each a single-cycle `in_valid` pulse followed by one idle cycle.
  - Required: `full`=1 two cycles after the last lane and still 1 ten cycles later; `rate_buf[i*64 +: 64]` equals lane i for every i; `ready`=0.
- Back-to-back lanes:
  - Stimulus: send the same 17 lanes on consecutive cycles.
  - Required: `full` rises right after the 17th edge, and the buffer contents are identical to the spaced case.
- Partial fill:
  - Stimulus: after 5 lanes, hold `in_valid`=0 for 20 cycles.
  - Required: `full`=0; bits [319:0] hold the 5 lanes; bits [1087:320] are 0; `ready`=1.
- Overflow while FULL:
  - Stimulus: after `full`, drive `in_valid`=1 with 64'hDEAD_BEEF_DEAD_BEEF for 5 cycles.
  - Required: `rate_buf` unchanged and `full`=1.
- Reset mid-fill and restart:
  - Stimulus: reset after 8 lanes, then send a fresh 17-lane block.
  - Required: immediately after reset, `rate_buf`=0, `full`=0, `ready`=1; the new block lands starting at [63:0].
- SHAKE128 width (`RATE_BITS`=1344):
  - Stimulus: send 21 lanes.
  - Required: `full` is not asserted after lane 17 and is asserted only after lane 21; the last lane is at [1343:1280].
